dmem_responder: RTL

Wait-stated data-memory responder for the 5-stage RISC-V core. It serves load/store requests from the EX/MEM stage through a valid/ready request channel and a valid/ready response channel. It models a slow memory with a fixed, programmable access latency, which gives the pipeline a real stall source. Storage is byte-addressed and little-endian, and it reports misaligned and out-of-range accesses.

---
 rtl/dmem_responder_if.sv | 24 ++
 rtl/dmem_responder.sv | 133 +++++++++++++
 2 files changed

// File: rtl/dmem_responder_if.sv
// Request/response channel between the EX/MEM stage and the data-memory responder.
// The master side is the pipeline; the slave side is the memory.
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_write, req_size, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_size, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Wait-stated, byte-addressed little-endian data memory with a valid/ready request and
// response channel; one access outstanding at a time, with misalign/range error reporting.
module dmem_responder #(
    parameter int unsigned DEPTH       = 512,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    dmem_responder_if.slave   bus,
    output logic              busy
);
    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        wr_q;
    logic [1:0]  size_q;
    logic [63:0] addr_q, wdata_q;
    logic [63:0] rdata_q, rdata_d;
    logic        err_q;
    logic [7:0]  mem_q [DEPTH];

    logic          accept, exec;
    logic          ex_write;
    logic [1:0]    ex_size;
    logic [63:0]   ex_addr, ex_wdata;
    logic [3:0]    ex_bytes;
    logic [64:0]   ex_end;
    logic [AW-1:0] ex_base;
    logic          ex_err;

    // req_ready is gated by reset so it stays low while reset is held.
    assign bus.req_ready  = (state_q == StIdle) && reset;
    assign bus.resp_valid = (state_q == StResp);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;
    assign busy           = (state_q != StIdle);
    assign accept         = bus.req_valid && bus.req_ready;

    // In IDLE the access may execute on the accept edge itself, so use the live fields.
    always_comb begin
        if (state_q == StIdle) begin
            ex_write = bus.req_write;
            ex_size  = bus.req_size;
            ex_addr  = bus.req_addr;
            ex_wdata = bus.req_wdata;
        end else begin
            ex_write = wr_q;
            ex_size  = size_q;
            ex_addr  = addr_q;
            ex_wdata = wdata_q;
        end
        ex_bytes = 4'd1 << ex_size;
        ex_end   = {1'b0, ex_addr} + {61'd0, ex_bytes};
        ex_err   = ((ex_addr[2:0] & (ex_bytes[2:0] - 3'd1)) != 3'd0) || (ex_end > 65'(DEPTH));
        ex_base  = ex_addr[AW-1:0];
        rdata_d  = '0;
        for (int i = 0; i < 8; i++) begin
            if (!ex_write && !ex_err && (i < int'(ex_bytes))) begin
                rdata_d[8*i +: 8] = mem_q[ex_base + AW'(i)];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        exec    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (WAIT_CYCLES == 0) begin
                        exec    = 1'b1;
                        state_d = StResp;
                    end else begin
                        cnt_d   = 4'(WAIT_CYCLES - 1);
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    exec    = 1'b1;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                if (bus.resp_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            size_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                wr_q    <= bus.req_write;
                size_q  <= bus.req_size;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
            end
            if (exec) begin
                rdata_q <= rdata_d;
                err_q   <= ex_err;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= 8'h00;
        end else if (exec && ex_write && !ex_err) begin
            for (int i = 0; i < 8; i++) begin
                if (i < int'(ex_bytes)) mem_q[ex_base + AW'(i)] <= ex_wdata[8*i +: 8];
            end
        end
    end
endmodule
